// File: rtl/cpu_jtag_debug_cmd_sync.sv
// cpu_jtag_debug_cmd_sync: moves JTAG update-DR/IR strobes into clk and queues captured {ir_in, sr} commands.
// Define DBG_CMD_FIFO_EN for a CMD_DEPTH-entry FIFO; otherwise a single holding register is used.
module cpu_jtag_debug_cmd_sync #(
  parameter int DR_W      = 38,
  parameter int IR_W      = 2,
  parameter int CMD_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DR_W-1:0]      sr,
  input  logic [IR_W-1:0]      ir_in,
  input  logic                 vs_udr,
  input  logic                 vs_uir,
  input  logic                 cmd_ready,
  input  logic                 ovf_clr,
  output logic [DR_W-1:0]      jdo,
  output logic [IR_W-1:0]      jir,
  output logic                 cmd_valid,
  output logic [2**IR_W-1:0]   take_action,
  output logic [2**IR_W-1:0]   take_no_action,
  output logic                 ir_update,
  output logic                 ovf
);
  localparam int NCH = 2**IR_W;
  localparam int W   = DR_W + IR_W;
  logic [2:0] udr_q, uir_q;
  logic [1:0] arm_q;
  logic armed, udr_rise, uir_rise, accept, drop, full, push;
  logic [W-1:0] head;
  logic [NCH-1:0] onehot, ta_d, tna_d, ta_q, tna_q;
  logic iru_q, ovf_q, ovf_d;
  // Rises are ignored until stage 3 has seen a post-reset stage 2, so a level high at release is not a capture
  assign armed    = arm_q == 2'd3;
  assign udr_rise = armed & udr_q[1] & ~udr_q[2];
  assign uir_rise = armed & uir_q[1] & ~uir_q[2];
  assign accept   = cmd_valid & cmd_ready;
  assign drop     = udr_rise & full & ~accept;
  assign push     = udr_rise & ~drop;
  assign {jir, jdo} = head;
  assign onehot = NCH'(1) << jir;
  assign ta_d   = accept & jdo[DR_W-1] ? onehot : '0;
  assign tna_d  = accept & ~jdo[DR_W-1] ? onehot : '0;
  assign ovf_d  = drop | (ovf_q & ~ovf_clr);
  assign take_action    = ta_q;
  assign take_no_action = tna_q;
  assign ir_update      = iru_q;
  assign ovf            = ovf_q;
  always_ff @(posedge clk)
    if (!reset_n) begin
      udr_q <= '0;
      uir_q <= '0;
      arm_q <= '0;
      ta_q  <= '0;
      tna_q <= '0;
      iru_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      udr_q <= {udr_q[1:0], vs_udr};
      uir_q <= {uir_q[1:0], vs_uir};
      arm_q <= armed ? arm_q : arm_q + 2'd1;
      ta_q  <= ta_d;
      tna_q <= tna_d;
      iru_q <= uir_rise;
      ovf_q <= ovf_d;
    end
`ifdef DBG_CMD_FIFO_EN
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [CMD_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  assign full      = cnt_q == CW'(CMD_DEPTH);
  assign cmd_valid = cnt_q != '0;
  assign head      = mem_q[rd_q];
  // When full, pop and push share a slot: the tail write lands on the entry being popped
  always_ff @(posedge clk)
    if (!reset_n) begin
      for (int i = 0; i < CMD_DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) mem_q[wr_q] <= {ir_in, sr};
      wr_q  <= wr_q + AW'(push);
      rd_q  <= rd_q + AW'(accept);
      cnt_q <= cnt_q + CW'(push) - CW'(accept);
    end
`else
  logic [W-1:0] hold_q;
  logic valid_q;
  assign full      = valid_q;
  assign cmd_valid = valid_q;
  assign head      = hold_q;
  always_ff @(posedge clk)
    if (!reset_n) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push) hold_q <= {ir_in, sr};
      valid_q <= push | (valid_q & ~accept);
    end
`endif
endmodule
